// File: rtl/stim_pkg.sv
// Definitions shared by the stimulus reader and the result checker:
// command codes, check-record layout, log marker and checker state encoding.
package stim_pkg;

  localparam int SCC_W = 5;
  localparam logic [SCC_W-1:0] SC_CMD_IDLE    = 5'b00000;
  localparam logic [SCC_W-1:0] SC_CMD_BITMASK = 5'b00001;

  // Check record is {expected, tv_addr}; tv_addr sits in the low bits.
  localparam int CHF_TADDR_LSB = 0;

  localparam logic [7:0] LOG_MARKER = 8'hFA;
  localparam int         LOG_WORDS  = 4;

  typedef enum logic [1:0] {
    CHK_IDLE    = 2'd0,
    CHK_LOAD    = 2'd1,
    CHK_COMPARE = 2'd2,
    CHK_WR_REC  = 2'd3
  } chk_state_t;

  function automatic int chf_exp_lsb(input int addr_width);
    return CHF_TADDR_LSB + addr_width;
  endfunction

endpackage

// File: rtl/result_log_writer.sv
// Avalon-MM write master for one 4-word failure record; address and data
// are held while the slave stalls, and abort drops the strobe next cycle.
module result_log_writer
  import stim_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 20,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    BE_WIDTH   = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] LOG_BASE   = 20'h80000
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                abort,
  input  logic                                start,
  input  logic [ADDR_WIDTH-1:0]               base_addr,
  input  logic [LOG_WORDS-1:0][DATA_WIDTH-1:0] rec_words,
  output logic                                busy,
  output logic                                rec_done,
  output logic [ADDR_WIDTH-1:0]               mem_address,
  output logic [BE_WIDTH-1:0]                 mem_byteenable,
  output logic                                mem_write,
  output logic [DATA_WIDTH-1:0]               mem_writedata,
  input  logic                                mem_waitrequest
);

  logic                                 write_q, write_d;
  logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
  logic [DATA_WIDTH-1:0]                data_q, data_d;
  logic [1:0]                           idx_q, idx_d;
  logic [LOG_WORDS-1:0][DATA_WIDTH-1:0] words_q, words_d;
  logic                                 accept;
  logic                                 last_word;

  assign accept    = write_q && !mem_waitrequest;
  assign last_word = (idx_q == 2'(LOG_WORDS - 1));

  always_comb begin
    write_d = write_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    words_d = words_q;
    if (start && !write_q) begin
      write_d = 1'b1;
      addr_d  = base_addr;
      data_d  = rec_words[0];
      idx_d   = 2'd0;
      words_d = rec_words;
    end else if (accept) begin
      if (last_word) begin
        write_d = 1'b0;
      end else begin
        idx_d  = idx_q + 2'd1;
        addr_d = addr_q + 1'b1;
        data_d = words_q[idx_q + 2'd1];
      end
    end
    if (abort) begin
      write_d = 1'b0;
      addr_d  = LOG_BASE;
      data_d  = '0;
      idx_d   = 2'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= LOG_BASE;
      data_q  <= '0;
      idx_q   <= 2'd0;
      words_q <= '0;
    end else begin
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      words_q <= words_d;
    end
  end

  assign busy           = write_q;
  assign rec_done       = accept && last_word;
  assign mem_write      = write_q;
  assign mem_address    = addr_q;
  assign mem_writedata  = data_q;
  assign mem_byteenable = '1;

endmodule

// File: rtl/result_check.sv
// Pops matched expected/result pairs, compares them under a host bitmask,
// counts passes/fails and logs each failure as a 4-word memory record.
//
// state       | meaning
// ------------+---------------------------------------------------------
// CHK_IDLE    | accept bitmask command; pop both FIFOs when both non-empty
// CHK_LOAD    | capture FIFO read data (valid one cycle after the pop)
// CHK_COMPARE | masked compare, update counters, start log or flag overflow
// CHK_WR_REC  | failure record in flight on the write master
module result_check
  import stim_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 20,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    BE_WIDTH    = DATA_WIDTH / 8,
  parameter int                    STF_WIDTH   = 24,
  parameter int                    CHF_WIDTH   = STF_WIDTH + ADDR_WIDTH,
  parameter int                    SCC_WIDTH   = 5,
  parameter int                    SCD_WIDTH   = 24,
  parameter logic [ADDR_WIDTH-1:0] LOG_BASE    = 20'h80000,
  parameter int                    LOG_RECORDS = 1024,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  done,
  input  logic [CHF_WIDTH-1:0]  cfifo_q,
  output logic                  cfifo_rdreq,
  input  logic                  cfifo_rdempty,
  input  logic [STF_WIDTH-1:0]  rfifo_q,
  output logic                  rfifo_rdreq,
  input  logic                  rfifo_rdempty,
  input  logic [SCC_WIDTH-1:0]  sc_cmd,
  input  logic [SCD_WIDTH-1:0]  sc_data,
  output logic                  sc_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BE_WIDTH-1:0]   mem_byteenable,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic                  mem_waitrequest,
  output logic [CNT_WIDTH-1:0]  check_count,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic                  log_overflow
);

  localparam int PTR_W   = $clog2(LOG_RECORDS + 1);
  localparam int EXP_LSB = chf_exp_lsb(ADDR_WIDTH);

  chk_state_t            state_q, state_d;
  logic [STF_WIDTH-1:0]  mask_q, mask_d;
  logic [STF_WIDTH-1:0]  exp_q, exp_d;
  logic [STF_WIDTH-1:0]  res_q, res_d;
  logic [ADDR_WIDTH-1:0] taddr_q, taddr_d;
  logic [CNT_WIDTH-1:0]  check_q, check_d;
  logic [CNT_WIDTH-1:0]  fail_q, fail_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  ovf_q, ovf_d;

  logic                                 pop;
  logic                                 start;
  logic                                 rec_done;
  logic                                 busy;
  logic [STF_WIDTH-1:0]                 diff;
  logic [ADDR_WIDTH-1:0]                base_addr;
  logic [LOG_WORDS-1:0][DATA_WIDTH-1:0] rec_words;

  assign diff      = (exp_q ^ res_q) & mask_q;
  assign base_addr = LOG_BASE + (ADDR_WIDTH'(ptr_q) << 2);

  assign rec_words[0] = DATA_WIDTH'({LOG_MARKER, 8'(taddr_q >> 16)});
  assign rec_words[1] = DATA_WIDTH'(taddr_q[15:0]);
  assign rec_words[2] = DATA_WIDTH'({8'h00, res_q[23:16]});
  assign rec_words[3] = DATA_WIDTH'(res_q[15:0]);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    exp_d   = exp_q;
    res_d   = res_q;
    taddr_d = taddr_q;
    check_d = check_q;
    fail_d  = fail_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    pop     = 1'b0;
    start   = 1'b0;
    case (state_q)
      CHK_IDLE: begin
        if (sc_cmd == SC_CMD_BITMASK) mask_d = sc_data[STF_WIDTH-1:0];
        if (!cfifo_rdempty && !rfifo_rdempty) begin
          pop     = 1'b1;
          state_d = CHK_LOAD;
        end
      end
      CHK_LOAD: begin
        exp_d   = cfifo_q[CHF_WIDTH-1 -: STF_WIDTH];
        taddr_d = cfifo_q[CHF_TADDR_LSB +: ADDR_WIDTH];
        res_d   = rfifo_q;
        state_d = CHK_COMPARE;
      end
      CHK_COMPARE: begin
        if (check_q != '1) check_d = check_q + 1'b1;
        state_d = CHK_IDLE;
        if (diff != '0) begin
          if (fail_q != '1) fail_d = fail_q + 1'b1;
          if (ptr_q < PTR_W'(LOG_RECORDS)) begin
            start   = 1'b1;
            state_d = CHK_WR_REC;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      CHK_WR_REC: begin
        if (rec_done) begin
          ptr_d   = ptr_q + 1'b1;
          state_d = CHK_IDLE;
        end
      end
      default: state_d = CHK_IDLE;
    endcase
    // Clear wins over everything, including a same-cycle bitmask command.
    if (clear) begin
      state_d = CHK_IDLE;
      mask_d  = '1;
      check_d = '0;
      fail_d  = '0;
      ptr_d   = '0;
      ovf_d   = 1'b0;
      pop     = 1'b0;
      start   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CHK_IDLE;
      mask_q  <= '1;
      exp_q   <= '0;
      res_q   <= '0;
      taddr_q <= '0;
      check_q <= '0;
      fail_q  <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      taddr_q <= taddr_d;
      check_q <= check_d;
      fail_q  <= fail_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  result_log_writer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (BE_WIDTH),
    .LOG_BASE   (LOG_BASE)
  ) u_log_writer (
    .clock           (clock),
    .reset           (reset),
    .abort           (clear),
    .start           (start),
    .base_addr       (base_addr),
    .rec_words       (rec_words),
    .busy            (busy),
    .rec_done        (rec_done),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_waitrequest (mem_waitrequest)
  );

  // A pop during reset would lose a FIFO entry the checker never sees.
  assign cfifo_rdreq  = pop && !reset;
  assign rfifo_rdreq  = pop && !reset;
  assign sc_ready     = (state_q == CHK_IDLE);
  assign done         = (state_q == CHK_IDLE) && cfifo_rdempty && rfifo_rdempty && !busy;
  assign check_count  = check_q;
  assign fail_count   = fail_q;
  assign log_overflow = ovf_q;

endmodule

// File: tb/tb_result_check.sv
// Scoreboard bench for result_check: FIFO and Avalon slave models, expected
// log writes queued when vectors are pushed and popped on each accepted write.
module tb_result_check;
  import stim_pkg::*;

  localparam int              AW = 20;
  localparam int              DW = 16;
  localparam int              BW = 2;
  localparam int              SW = 24;
  localparam int              CW = SW + AW;
  localparam int              CNTW = 16;
  localparam int              LR = 2;
  localparam logic [AW-1:0]   LB = 20'h80000;

  logic            clock, reset, clear, done;
  logic [CW-1:0]   cfifo_q;
  logic            cfifo_rdreq, cfifo_rdempty;
  logic [SW-1:0]   rfifo_q;
  logic            rfifo_rdreq, rfifo_rdempty;
  logic [4:0]      sc_cmd;
  logic [23:0]     sc_data;
  logic            sc_ready;
  logic [AW-1:0]   mem_address;
  logic [BW-1:0]   mem_byteenable;
  logic            mem_write;
  logic [DW-1:0]   mem_writedata;
  logic            mem_waitrequest;
  logic [CNTW-1:0] check_count, fail_count;
  logic            log_overflow;

  result_check #(.LOG_RECORDS(LR)) dut (
    .clock(clock), .reset(reset), .clear(clear), .done(done),
    .cfifo_q(cfifo_q), .cfifo_rdreq(cfifo_rdreq), .cfifo_rdempty(cfifo_rdempty),
    .rfifo_q(rfifo_q), .rfifo_rdreq(rfifo_rdreq), .rfifo_rdempty(rfifo_rdempty),
    .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_ready(sc_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest),
    .check_count(check_count), .fail_count(fail_count), .log_overflow(log_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  bit stall_mode = 0;
  bit force_wait = 0;
  int stall_cnt = 0;

  logic [CW-1:0]    cq[$];
  logic [SW-1:0]    rq[$];
  logic [AW+DW-1:0] exp_wr[$];

  logic [SW-1:0]   mask_m;
  logic [CNTW-1:0] chk_m, fail_m;
  int              ptr_m;
  bit              ovf_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  task automatic model_reset();
    mask_m = '1; chk_m = '0; fail_m = '0; ptr_m = 0; ovf_m = 0;
    exp_wr.delete();
  endtask

  task automatic model_vec(input logic [SW-1:0] e, input logic [SW-1:0] r, input logic [AW-1:0] ta);
    logic [DW-1:0] w [4];
    logic [AW-1:0] a;
    if (chk_m != 16'hFFFF) chk_m++;
    if (((e ^ r) & mask_m) != '0) begin
      if (fail_m != 16'hFFFF) fail_m++;
      if (ptr_m < LR) begin
        w[0] = {8'hFA, 4'h0, ta[19:16]};
        w[1] = ta[15:0];
        w[2] = {8'h00, r[23:16]};
        w[3] = r[15:0];
        for (int k = 0; k < 4; k++) begin
          a = AW'(LB + AW'(ptr_m * 4 + k));
          exp_wr.push_back({a, w[k]});
        end
        ptr_m++;
      end else begin
        ovf_m = 1;
      end
    end
  endtask

  task automatic push_vec(input logic [SW-1:0] e, input logic [SW-1:0] r, input logic [AW-1:0] ta,
                          input bit push_r);
    @(negedge clock);
    model_vec(e, r, ta);
    cq.push_back({e, ta});
    cfifo_rdempty = 1'b0;
    if (push_r) begin
      rq.push_back(r);
      rfifo_rdempty = 1'b0;
    end
  endtask

  task automatic push_res(input logic [SW-1:0] r);
    @(negedge clock);
    rq.push_back(r);
    rfifo_rdempty = 1'b0;
  endtask

  task automatic set_mask(input logic [SW-1:0] m);
    @(negedge clock);
    check("sc_ready", 32'(sc_ready), 32'd1);
    sc_cmd = SC_CMD_BITMASK; sc_data = m;
    @(negedge clock);
    sc_cmd = SC_CMD_IDLE; sc_data = '0;
    mask_m = m;
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    model_reset();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clock);
    while (!(done && cq.size() == 0 && rq.size() == 0) && n < 300) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_check_count"}, 32'(check_count), 32'(chk_m));
    check({tag, "_fail_count"}, 32'(fail_count), 32'(fail_m));
    check({tag, "_overflow"}, 32'(log_overflow), 32'(ovf_m));
  endtask

  // FIFO models: read data appears one cycle after rdreq.
  always @(posedge clock) begin
    if (cfifo_rdreq && cq.size() != 0) cfifo_q <= cq.pop_front();
    if (rfifo_rdreq && rq.size() != 0) rfifo_q <= rq.pop_front();
    cfifo_rdempty <= (cq.size() == 0);
    rfifo_rdempty <= (rq.size() == 0);
  end

  // Slave stall: two waitrequest cycles per word when stall_mode is set.
  always @(posedge clock) begin
    #1;
    if (force_wait) mem_waitrequest = 1'b1;
    else if (stall_mode && mem_write) begin
      if (stall_cnt < 2) begin mem_waitrequest = 1'b1; stall_cnt++; end
      else begin mem_waitrequest = 1'b0; stall_cnt = 0; end
    end else begin
      mem_waitrequest = 1'b0; stall_cnt = 0;
    end
  end

  always @(negedge clock) begin
    logic [AW+DW-1:0] e;
    if (cfifo_rdreq || rfifo_rdreq) begin
      check("rdreq_pair", 32'(cfifo_rdreq), 32'(rfifo_rdreq));
      check("pop_nonempty", 32'(cq.size() != 0 && rq.size() != 0), 32'd1);
    end
    if (mem_write && !mem_waitrequest) begin
      wr_cnt++;
      if (exp_wr.size() == 0) check("unexpected_write", 32'(exp_wr.size()), 32'd1);
      else begin
        e = exp_wr.pop_front();
        check("wr_addr", 32'(mem_address), 32'(e[AW+DW-1:DW]));
        check("wr_data", 32'(mem_writedata), 32'(e[DW-1:0]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    bit found;
    bit bad;
    reset = 1'b1; clear = 1'b0; sc_cmd = SC_CMD_IDLE; sc_data = '0;
    cfifo_rdempty = 1'b1; rfifo_rdempty = 1'b1; cfifo_q = '0; rfifo_q = '0;
    mem_waitrequest = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_mem_address", 32'(mem_address), 32'(LB));
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_writedata", 32'(mem_writedata), 32'd0);
    check("rst_byteenable", 32'(mem_byteenable), 32'h3);
    check("rst_sc_ready", 32'(sc_ready), 32'd1);
    check("rst_done", 32'(done), 32'd1);
    check_counts("rst");
    reset = 1'b0;

    // Matching pass
    push_vec(24'h00A5A5, 24'h00A5A5, 20'h00010, 1);
    wait_done("pass");
    check_counts("pass");
    check("pass_no_write", 32'(wr_cnt), 32'd0);

    // Masked mismatch passes
    set_mask(24'hFFFF00);
    push_vec(24'h123456, 24'h1234FF, 20'h00020, 1);
    wait_done("masked");
    check_counts("masked");
    check("masked_no_write", 32'(wr_cnt), 32'd0);

    // Failure log under stalls
    do_clear();
    check_counts("clear1");
    stall_mode = 1;
    base = wr_cnt;
    push_vec(24'h000001, 24'h000000, 20'h3ABCD, 1);
    wait_done("stall");
    check_counts("stall");
    check("stall_words", 32'(wr_cnt - base), 32'd4);

    // Log full: second record logged, third overflows
    push_vec(24'h000002, 24'h000000, 20'h11111, 1);
    push_vec(24'h000004, 24'hC30000, 20'h22222, 1);
    wait_done("full");
    check_counts("full");
    check("full_words", 32'(wr_cnt - base), 32'd8);
    check("full_pending", 32'(exp_wr.size()), 32'd0);
    stall_mode = 0;

    // Clear while a record is in flight, after w1 is accepted
    do_clear();
    set_mask(24'hFFFF00);
    push_vec(24'h100000, 24'h000000, 20'h00055, 1);
    found = 0;
    n = 0;
    while (!found && n < 100) begin
      @(negedge clock);
      if (mem_write && !mem_waitrequest && mem_address == LB + 20'd1) begin
        force_wait = 1;
        found = 1;
      end
      n++;
    end
    check("clr_w1_seen", 32'(found), 32'd1);
    @(negedge clock);
    check("clr_w2_pending", 32'(mem_write), 32'd1);
    clear = 1'b1;
    sc_cmd = SC_CMD_BITMASK; sc_data = 24'hFF0000;
    @(negedge clock);
    check("clr_write_drop", 32'(mem_write), 32'd0);
    clear = 1'b0; sc_cmd = SC_CMD_IDLE; sc_data = '0; force_wait = 0;
    model_reset();
    check_counts("clr");
    push_vec(24'h000001, 24'h000000, 20'h00042, 1);
    wait_done("after_clr");
    check_counts("after_clr");
    check("after_clr_pending", 32'(exp_wr.size()), 32'd0);

    // Result FIFO empty: nothing may be popped
    for (int i = 0; i < 3; i++) push_vec(24'(i + 7), 24'(i + 7), 20'(i), 0);
    bad = 0;
    repeat (10) begin
      @(negedge clock);
      if (cfifo_rdreq || rfifo_rdreq) bad = 1;
    end
    check("one_empty_no_pop", 32'(bad), 32'd0);
    check("one_empty_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) push_res(24'(i + 7));
    wait_done("one_empty");
    check_counts("one_empty");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
